// File: rtl/arb_pkg.sv
// Shared types for the IF/LS memory arbiter.
// State codes, owner codes and perf counter helpers.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int PERF_W = 16;

  function automatic logic [PERF_W-1:0] sat_inc(
    input logic [PERF_W-1:0] v
  );
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker for the memory arbiter.
// On a tie the requester that did not own the last grant wins.
module rr_pick2
  import arb_pkg::*;
(
  input  logic req_if,
  input  logic req_ls,
  input  logic last_owner,
  output logic gnt_if,
  output logic gnt_ls
);

  assign gnt_if = req_if &
    (~req_ls | (last_owner == OWN_LS));
  assign gnt_ls = req_ls &
    (~req_if | (last_owner == OWN_IF));

endmodule

// File: rtl/mem_arbiter.sv
// IF/LS arbiter in front of a single-port memory.
// Optional perf counters: define MEM_ARBITER_PERF_EN.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_if_grants,
  output logic [PERF_W-1:0] perf_ls_grants,
  output logic [PERF_W-1:0] perf_conflicts
`endif
);

  localparam int BE_W = DATA_W / 8;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_owner;
  logic              r_last;
  logic              r_mem_req;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_if_rvalid;
  logic              r_ls_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

  logic w_idle;
  logic w_req_if;
  logic w_req_ls;
  logic w_gnt_if;
  logic w_gnt_ls;
  logic w_grant;
  logic w_accept;
  logic w_rdone;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_req_if = if_req & w_idle;
  assign w_req_ls = ls_req & w_idle;

  rr_pick2 u_pick (
    .req_if     (w_req_if),
    .req_ls     (w_req_ls),
    .last_owner (r_last),
    .gnt_if     (w_gnt_if),
    .gnt_ls     (w_gnt_ls)
  );

  assign w_grant  = w_gnt_if | w_gnt_ls;
  assign w_accept = (r_state == ST_ISSUE) & mem_ready;
  assign w_rdone  = (r_state == ST_WAIT) & mem_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_grant) w_state_nxt = ST_ISSUE;
      ST_ISSUE:
        if (mem_ready)
          w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
      ST_WAIT:
        if (mem_rvalid) w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  // Request bundle is held from grant until the accept cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= OWN_IF;
      r_last    <= OWN_IF;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_grant) begin
      r_owner   <= w_gnt_ls ? OWN_LS : OWN_IF;
      r_last    <= w_gnt_ls ? OWN_LS : OWN_IF;
      r_mem_req <= 1'b1;
      if (w_gnt_ls) begin
        r_we    <= ls_we;
        r_be    <= ls_be;
        r_addr  <= ls_addr;
        r_wdata <= ls_wdata;
      end else begin
        r_we    <= 1'b0;
        r_be    <= '1;
        r_addr  <= if_addr;
        r_wdata <= '0;
      end
    end else if (w_accept) begin
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      if (w_accept && r_we) begin
        r_ls_rvalid <= 1'b1;
        r_ls_rdata  <= '0;
      end
      if (w_rdone) begin
        if (r_owner == OWN_LS) begin
          r_ls_rvalid <= 1'b1;
          r_ls_rdata  <= mem_rdata;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = w_gnt_if;
  assign ls_gnt    = w_gnt_ls;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_rvalid = r_ls_rvalid;
  assign ls_rdata  = r_ls_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = ~w_idle;

`ifdef MEM_ARBITER_PERF_EN
  logic [PERF_W-1:0] r_perf_if;
  logic [PERF_W-1:0] r_perf_ls;
  logic [PERF_W-1:0] r_perf_cf;
  logic              w_conflict;

  assign w_conflict = w_idle & if_req & ls_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_if <= '0;
      r_perf_ls <= '0;
      r_perf_cf <= '0;
    end else begin
      if (w_gnt_if)   r_perf_if <= sat_inc(r_perf_if);
      if (w_gnt_ls)   r_perf_ls <= sat_inc(r_perf_ls);
      if (w_conflict) r_perf_cf <= sat_inc(r_perf_cf);
    end
  end

  assign perf_if_grants = r_perf_if;
  assign perf_ls_grants = r_perf_ls;
  assign perf_conflicts = r_perf_cf;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases
// followed by random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [3:0]  ls_be = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
`ifdef MEM_ARBITER_PERF_EN
  logic [15:0] perf_if_grants;
  logic [15:0] perf_ls_grants;
  logic [15:0] perf_conflicts;
`endif

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_be      (ls_be),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
`ifdef MEM_ARBITER_PERF_EN
    ,
    .perf_if_grants (perf_if_grants),
    .perf_ls_grants (perf_ls_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Transaction-level model state
  logic [31:0] mem_m [16];
  bit          out_busy, out_acc, out_own, out_we;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_be;
  bit          last_own;
  bit          rd_pending, deliver;
  int          rd_wait;
  logic [31:0] rd_data;
  bit          rd_own;
  bit          done_next, exp_done, done_own, exp_own;
  logic [31:0] done_data, exp_data;
  bit          drop_if, drop_ls, e_if, e_ls, exp_mreq;
  int          m_if_g, m_ls_g, m_conf;

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_ifrv", if_rvalid, 0);
    chk("rst_lsrv", ls_rvalid, 0);
    chk("rst_be", mem_be, 0);
    cyc(); rst = 1'b1;

    // Single IF read, minimum latency
    cyc(); if_req = 1; if_addr = 32'h100;
    #1 chk("rd_gnt", if_gnt, 1);
    chk("rd_lsgnt", ls_gnt, 0);
    cyc(); if_req = 0; mem_ready = 1;
    #1 chk("rd_mreq", mem_req, 1);
    chk("rd_addr", mem_addr, 32'h100);
    chk("rd_we", mem_we, 0);
    chk("rd_be", mem_be, 4'hf);
    chk("rd_rv1", if_rvalid, 0);
    cyc(); mem_ready = 0; mem_rvalid = 1;
    mem_rdata = 32'hDEADBEEF;
    #1 chk("rd_mreq_drop", mem_req, 0);
    chk("rd_rv2", if_rvalid, 0);
    cyc(); mem_rvalid = 0;
    #1 chk("rd_rv3", if_rvalid, 1);
    chk("rd_data", if_rdata, 32'hDEADBEEF);
    chk("rd_lsrv", ls_rvalid, 0);
    chk("rd_idle", busy, 0);
    cyc();
    #1 chk("rd_rv4", if_rvalid, 0);
    chk("rd_hold", if_rdata, 32'hDEADBEEF);

    // Reset while waiting for read data
    cyc(); if_req = 1; if_addr = 32'h200;
    cyc(); if_req = 0; mem_ready = 1;
    cyc(); mem_ready = 0;
    #1 chk("mw_busy", busy, 1);
    rst = 0;
    #1 chk("mw_rbusy", busy, 0);
    chk("mw_rmreq", mem_req, 0);
    chk("mw_rdata", if_rdata, 0);
    cyc(); rst = 1; mem_rvalid = 1; mem_rdata = 32'h1234;
    cyc(); mem_rvalid = 0;
    #1 chk("mw_ifrv", if_rvalid, 0);
    chk("mw_lsrv", ls_rvalid, 0);
    chk("mw_idle", busy, 0);

    // Both requesting: alternate LS, IF, LS, IF
    cyc(); if_req = 1; ls_req = 1; ls_we = 0;
    ls_addr = 32'h80; if_addr = 32'h90;
    for (int i = 0; i < 4; i++) begin
      #1 chk("tie_lsgnt", ls_gnt, (i % 2 == 0));
      chk("tie_ifgnt", if_gnt, (i % 2 == 1));
      cyc(); mem_ready = 1;
      #1 chk("tie_addr", mem_addr,
             (i % 2 == 0) ? 32'h80 : 32'h90);
      cyc(); mem_ready = 0; mem_rvalid = 1;
      mem_rdata = 32'h100 + i;
      if (i == 3) begin if_req = 0; ls_req = 0; end
      cyc(); mem_rvalid = 0;
      #1 chk("tie_lsrv", ls_rvalid, (i % 2 == 0));
      chk("tie_ifrv", if_rvalid, (i % 2 == 1));
    end
`ifdef MEM_ARBITER_PERF_EN
    chk("perf_cf", perf_conflicts, 4);
    chk("perf_if", perf_if_grants, 2);
    chk("perf_ls", perf_ls_grants, 2);
`endif

    // Spurious memory signals in IDLE
    cyc(); mem_rvalid = 1; mem_ready = 1; mem_rdata = 32'hBAD;
    #1 chk("sp_busy", busy, 0);
    cyc(); mem_rvalid = 0; mem_ready = 0;
    #1 chk("sp_ifrv", if_rvalid, 0);
    chk("sp_lsrv", ls_rvalid, 0);
    chk("sp_idle", busy, 0);
    chk("sp_mreq", mem_req, 0);

    // LS write with stalled accept; spurious rvalid in ISSUE
    cyc(); ls_req = 1; ls_we = 1; ls_addr = 32'h40;
    ls_wdata = 32'hA5A5A5A5; ls_be = 4'b0011;
    #1 chk("wr_gnt", ls_gnt, 1);
    cyc(); ls_req = 0; ls_we = 0;
    if_req = 1; if_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      mem_rvalid = (k < 3);
      mem_rdata = 32'hBAD0 + k;
      #1 chk("wr_mreq", mem_req, 1);
      chk("wr_addr", mem_addr, 32'h40);
      chk("wr_wdata", mem_wdata, 32'hA5A5A5A5);
      chk("wr_be", mem_be, 4'b0011);
      chk("wr_we", mem_we, 1);
      chk("wr_ifgnt", if_gnt, 0);
      chk("wr_lsrv", ls_rvalid, 0);
      cyc();
    end
    mem_ready = 0; mem_rvalid = 0;
    #1 chk("wr_ack", ls_rvalid, 1);
    chk("wr_rdata", ls_rdata, 0);
    chk("wr_drop", mem_req, 0);
    chk("wr_ifgnt2", if_gnt, 1);
    cyc(); if_req = 0; mem_ready = 1;
    #1 chk("wr_if_addr", mem_addr, 32'h300);
    chk("wr_if_be", mem_be, 4'hf);
    chk("wr_if_we", mem_we, 0);
    cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h33;
    cyc(); mem_rvalid = 0;
    #1 chk("wr_if_rv", if_rvalid, 1);
    chk("wr_if_data", if_rdata, 32'h33);

    // Back-to-back IF reads
    cyc(); if_req = 1; if_addr = 32'h500;
    #1 chk("bb_gnt1", if_gnt, 1);
    cyc(); if_addr = 32'h504; mem_ready = 1;
    #1 chk("bb_mreq1", mem_req, 1);
    chk("bb_addr1", mem_addr, 32'h500);
    chk("bb_nogn", if_gnt, 0);
    cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h11;
    #1 chk("bb_gap1", mem_req, 0);
    cyc(); mem_rvalid = 0;
    #1 chk("bb_rv1", if_rvalid, 1);
    chk("bb_gnt2", if_gnt, 1);
    chk("bb_gap2", mem_req, 0);
    chk("bb_data1", if_rdata, 32'h11);
    cyc(); if_req = 0; mem_ready = 1;
    #1 chk("bb_mreq2", mem_req, 1);
    chk("bb_addr2", mem_addr, 32'h504);
    cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h22;
    cyc(); mem_rvalid = 0;
    #1 chk("bb_rv2", if_rvalid, 1);
    chk("bb_data2", if_rdata, 32'h22);

    // Random traffic
    cyc(); rst = 0; if_req = 0; ls_req = 0;
    mem_ready = 0; mem_rvalid = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    cyc(); rst = 1;
    out_busy = 0; out_acc = 0; last_own = 0;
    rd_pending = 0; done_next = 0;
    drop_if = 0; drop_ls = 0;
    m_if_g = 0; m_ls_g = 0; m_conf = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      exp_done = done_next; exp_own = done_own;
      exp_data = done_data; done_next = 0;
      if (drop_if) if_req = 0;
      if (drop_ls) ls_req = 0;
      drop_if = 0; drop_ls = 0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1;
        if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!ls_req && $urandom_range(0, 3) == 0) begin
        ls_req = 1;
        ls_we = 1'($urandom);
        ls_be = 4'($urandom);
        ls_wdata = $urandom;
        ls_addr = 32'($urandom_range(0, 15)) << 2;
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      deliver = rd_pending && (rd_wait == 0);
      if (deliver) begin
        mem_rvalid = 1; mem_rdata = rd_data;
      end else begin
        mem_rvalid = !rd_pending && ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
      end
      #1;
      // completions
      chk("r_ifrv", if_rvalid, exp_done && !exp_own);
      chk("r_lsrv", ls_rvalid, exp_done && exp_own);
      if (exp_done) begin
        chk("r_rdata", exp_own ? ls_rdata : if_rdata, exp_data);
        out_busy = 0;
      end
      // memory returns read data
      if (deliver) begin
        rd_pending = 0; done_next = 1;
        done_own = rd_own; done_data = rd_data;
      end else if (rd_pending) begin
        rd_wait--;
      end
      // memory request side
      exp_mreq = out_busy && !out_acc;
      chk("r_mreq", mem_req, exp_mreq);
      if (exp_mreq) begin
        chk("r_maddr", mem_addr, out_addr);
        chk("r_mwe", mem_we, out_we);
        chk("r_mbe", mem_be, out_be);
        if (out_we) chk("r_mwd", mem_wdata, out_wdata);
        if (mem_ready) begin
          out_acc = 1;
          if (out_we) begin
            for (int b = 0; b < 4; b++)
              if (out_be[b])
                mem_m[out_addr[5:2]][8*b +: 8] = out_wdata[8*b +: 8];
            done_next = 1; done_own = 1; done_data = 0;
          end else begin
            rd_pending = 1;
            rd_wait = $urandom_range(0, 2);
            rd_data = mem_m[out_addr[5:2]];
            rd_own = out_own;
          end
        end
      end
      // grant decision
      e_if = 0; e_ls = 0;
      if (!out_busy) begin
        if (if_req && ls_req) begin
          m_conf++;
          e_if = last_own; e_ls = !last_own;
        end else begin
          e_if = if_req; e_ls = ls_req;
        end
      end
      chk("r_ifgnt", if_gnt, e_if);
      chk("r_lsgnt", ls_gnt, e_ls);
      if (e_if || e_ls) begin
        out_busy = 1; out_acc = 0;
        out_own = e_ls; last_own = e_ls;
        if (e_ls) begin
          m_ls_g++; drop_ls = 1;
          out_we = ls_we; out_be = ls_be;
          out_addr = ls_addr; out_wdata = ls_wdata;
        end else begin
          m_if_g++; drop_if = 1;
          out_we = 0; out_be = 4'hf;
          out_addr = if_addr; out_wdata = 0;
        end
      end
    end
    cyc();
`ifdef MEM_ARBITER_PERF_EN
    chk("r_perf_if", perf_if_grants, m_if_g);
    chk("r_perf_ls", perf_ls_grants, m_ls_g);
    chk("r_perf_cf", perf_conflicts, m_conf);
`endif
    chk("r_grants", (m_if_g > 20) && (m_ls_g > 20), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
